// File: rtl/csr_timer_if.sv
// CSR read/write bus shared by the CSR file and the constant-timer unit,
// plus the timer-interrupt line that feeds ESTAT[11].
interface csr_timer_if #(
    parameter int ADDR_W = 14
);
    logic              write_en;
    logic [ADDR_W-1:0] write_addr;
    logic [31:0]       write_data;
    logic              read_en;
    logic [ADDR_W-1:0] read_addr;
    logic [31:0]       read_data;
    logic              read_hit;
    logic              is_ti;

    modport master (
        output write_en, write_addr, write_data, read_en, read_addr,
        input  read_data, read_hit, is_ti
    );

    modport slave (
        input  write_en, write_addr, write_data, read_en, read_addr,
        output read_data, read_hit, is_ti
    );
endinterface

// File: rtl/csr_timer.sv
// LoongArch32 constant timer: owns TID/TCFG/TVAL/TICLR, counts TVAL down and
// raises the timer-interrupt pending bit on expiry.
module csr_timer #(
    parameter int          TIMER_N = 32,
    parameter logic [31:0] CPU_ID  = 32'h0,
    parameter int          ADDR_W  = 14
) (
    input  logic         clk,
    input  logic         rst,
    csr_timer_if.slave   bus
);
    localparam int NUM_CSR = 4;
    localparam logic [ADDR_W-1:0] A_TID   = ADDR_W'(12'h040);
    localparam logic [ADDR_W-1:0] A_TCFG  = ADDR_W'(12'h041);
    localparam logic [ADDR_W-1:0] A_TVAL  = ADDR_W'(12'h042);
    localparam logic [ADDR_W-1:0] A_TICLR = ADDR_W'(12'h044);
    localparam logic [ADDR_W-1:0] CSR_ADDR [NUM_CSR] = '{A_TID, A_TCFG, A_TVAL, A_TICLR};

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_EXPIRED
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [31:0]          r_tid;
    logic [TIMER_N-1:0]   r_tcfg;
    logic [TIMER_N-1:0]   r_tval;
    logic [TIMER_N-1:0]   w_tval_next;
    logic                 r_is_ti;
    logic                 w_is_ti_next;
    logic                 w_expire;

    logic                 w_we_tid;
    logic                 w_we_tcfg;
    logic                 w_we_ticlr;
    logic [TIMER_N-1:0]   w_reload_cfg;
    logic [TIMER_N-1:0]   w_reload_wr;
    logic                 w_periodic;

    logic [NUM_CSR-1:0]   w_rd_sel;
    logic [31:0]          w_csr_rdata [NUM_CSR];

    // ---------------------------------------------------------------
    // Write decode and reload values
    // ---------------------------------------------------------------
    assign w_we_tid   = bus.write_en && (bus.write_addr == A_TID);
    assign w_we_tcfg  = bus.write_en && (bus.write_addr == A_TCFG);
    assign w_we_ticlr = bus.write_en && (bus.write_addr == A_TICLR) && bus.write_data[0];

    assign w_periodic   = r_tcfg[1];
    assign w_reload_cfg = {r_tcfg[TIMER_N-1:2], 2'b00};
    assign w_reload_wr  = {bus.write_data[TIMER_N-1:2], 2'b00};

    // ---------------------------------------------------------------
    // State machine: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---------------------------------------------------------------
    // State machine: next state, counter and expiry
    // ---------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_tval_next  = r_tval;
        w_expire     = 1'b0;

        case (r_state)
            S_RUN: begin
                if (r_tval > TIMER_N'(1)) begin
                    w_tval_next = r_tval - TIMER_N'(1);
                end else begin
                    // Both 1 and 0 count as terminal so InitVal=0 still fires.
                    w_expire = 1'b1;
                    if (w_periodic) begin
                        w_tval_next = w_reload_cfg;
                    end else begin
                        w_tval_next  = '0;
                        w_state_next = S_EXPIRED;
                    end
                end
            end
            S_EXPIRED: begin
                w_tval_next = '0;
            end
            default: begin
                w_tval_next = r_tval;
            end
        endcase

        // A TCFG write restarts the counter from any state and wins over the
        // countdown, including an expiry that would have happened this edge.
        if (w_we_tcfg) begin
            w_expire     = 1'b0;
            w_tval_next  = w_reload_wr;
            w_state_next = bus.write_data[0] ? S_RUN : S_IDLE;
        end
    end

    // Expiry setting the pending bit has priority over a same-edge clear.
    always_comb begin
        w_is_ti_next = r_is_ti;
        if (w_expire) begin
            w_is_ti_next = 1'b1;
        end else if (w_we_ticlr) begin
            w_is_ti_next = 1'b0;
        end
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tid   <= CPU_ID;
            r_tcfg  <= '0;
            r_tval  <= '0;
            r_is_ti <= 1'b0;
        end else begin
            r_tval  <= w_tval_next;
            r_is_ti <= w_is_ti_next;
            if (w_we_tid) begin
                r_tid <= bus.write_data;
            end
            if (w_we_tcfg) begin
                r_tcfg <= bus.write_data[TIMER_N-1:0];
            end
        end
    end

    assign bus.is_ti = r_is_ti;

    // ---------------------------------------------------------------
    // Read path: combinational, reflects pre-write register values
    // ---------------------------------------------------------------
    assign w_csr_rdata[0] = r_tid;
    assign w_csr_rdata[1] = 32'(r_tcfg);
    assign w_csr_rdata[2] = 32'(r_tval);
    assign w_csr_rdata[3] = 32'h0;

    generate
        for (genvar gi = 0; gi < NUM_CSR; gi++) begin : g_rd_sel
            assign w_rd_sel[gi] = bus.read_en && (bus.read_addr == CSR_ADDR[gi]);
        end
    endgenerate

    always_comb begin
        bus.read_data = 32'h0;
        for (int i = 0; i < NUM_CSR; i++) begin
            if (w_rd_sel[i]) begin
                bus.read_data = bus.read_data | w_csr_rdata[i];
            end
        end
    end

    assign bus.read_hit = |w_rd_sel;

endmodule

// File: tb/tb_csr_timer.sv
// Directed bench for csr_timer: stimulus pushes expected read responses into a
// queue, a negedge monitor pops and compares them against the DUT.
module tb_csr_timer;
    localparam int          ADDR_W  = 14;
    localparam logic [31:0] CPU_ID  = 32'h0000_0007;
    localparam logic [13:0] A_TID   = 14'h040;
    localparam logic [13:0] A_TCFG  = 14'h041;
    localparam logic [13:0] A_TVAL  = 14'h042;
    localparam logic [13:0] A_TICLR = 14'h044;

    typedef struct {
        logic [31:0] data;
        logic        hit;
        logic        ti;
        string       name;
    } exp_t;

    logic   clk;
    logic   rst;
    logic   mon_valid;
    exp_t   exp_q[$];
    int     checks;
    int     errors;

    csr_timer_if #(.ADDR_W(ADDR_W)) bus ();

    csr_timer #(
        .TIMER_N (32),
        .CPU_ID  (CPU_ID),
        .ADDR_W  (ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compares every presented read against the next expectation.
    always @(negedge clk) begin
        if (mon_valid) begin
            exp_t e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_underflow: read with no expectation");
            end else begin
                e = exp_q.pop_front();
                $display("rd %-12s data=%08h hit=%b ti=%b", e.name, bus.read_data, bus.read_hit, bus.is_ti);
                if (bus.read_data !== e.data || bus.read_hit !== e.hit || bus.is_ti !== e.ti) begin
                    errors++;
                    $display("FAIL %s: got data=%08h hit=%b ti=%b expected data=%08h hit=%b ti=%b",
                             e.name, bus.read_data, bus.read_hit, bus.is_ti, e.data, e.hit, e.ti);
                end
            end
        end
    end

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        bus.write_en   = 1'b1;
        bus.write_addr = a;
        bus.write_data = d;
        @(posedge clk);
        #1;
        bus.write_en   = 1'b0;
    endtask

    task automatic rd(input logic en, input logic [13:0] a, input logic [31:0] d,
                      input logic h, input logic t, input string nm);
        exp_t e;
        e.data = d;
        e.hit  = h;
        e.ti   = t;
        e.name = nm;
        exp_q.push_back(e);
        bus.read_en   = en;
        bus.read_addr = a;
        mon_valid     = 1'b1;
        @(posedge clk);
        #1;
        bus.read_en   = 1'b0;
        mon_valid     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks         = 0;
        errors         = 0;
        mon_valid      = 1'b0;
        rst            = 1'b1;
        bus.write_en   = 1'b0;
        bus.write_addr = '0;
        bus.write_data = '0;
        bus.read_en    = 1'b0;
        bus.read_addr  = '0;
        idle(3);
        rst = 1'b0;

        // Reset values and decode
        rd(1'b1, A_TCFG,  32'h0,  1'b1, 1'b0, "rst_tcfg");
        rd(1'b1, A_TVAL,  32'h0,  1'b1, 1'b0, "rst_tval");
        rd(1'b1, A_TICLR, 32'h0,  1'b1, 1'b0, "rst_ticlr");
        rd(1'b1, A_TID,   CPU_ID, 1'b1, 1'b0, "rst_tid");
        rd(1'b1, 14'h005, 32'h0,  1'b0, 1'b0, "miss_0x05");
        rd(1'b0, A_TID,   32'h0,  1'b0, 1'b0, "rd_en_off");

        // One-shot InitVal=2: 8..1 then 0 with is_ti, no re-fire
        wr(A_TCFG, 32'h0000_0009);
        for (int i = 0; i < 8; i++) rd(1'b1, A_TVAL, 32'(8 - i), 1'b1, 1'b0, "oneshot_cnt");
        rd(1'b1, A_TVAL, 32'h0, 1'b1, 1'b1, "oneshot_exp");
        wr(A_TICLR, 32'h1);
        idle(20);
        rd(1'b1, A_TVAL, 32'h0, 1'b1, 1'b0, "oneshot_hold");
        rd(1'b1, A_TCFG, 32'h9, 1'b1, 1'b0, "oneshot_tcfg");

        // Periodic InitVal=1: 4,3,2,1,4...
        wr(A_TCFG, 32'h0000_0007);
        for (int i = 0; i < 4; i++) rd(1'b1, A_TVAL, 32'(4 - i), 1'b1, 1'b0, "per_cnt");
        rd(1'b1, A_TVAL, 32'h4, 1'b1, 1'b1, "per_exp1");
        wr(A_TICLR, 32'h1);
        rd(1'b1, A_TVAL, 32'h2, 1'b1, 1'b0, "per_clr");
        rd(1'b1, A_TVAL, 32'h1, 1'b1, 1'b0, "per_cnt2");
        rd(1'b1, A_TVAL, 32'h4, 1'b1, 1'b1, "per_exp2");

        // Clear colliding with expiry: set wins; TICLR=0 never clears
        wr(A_TICLR, 32'h1);
        rd(1'b1, A_TVAL, 32'h2, 1'b1, 1'b0, "coll_pre");
        wr(A_TICLR, 32'h1);
        rd(1'b1, A_TVAL, 32'h4, 1'b1, 1'b1, "coll_setwin");
        wr(A_TICLR, 32'h0);
        wr(A_TICLR, 32'h0);
        rd(1'b1, A_TVAL, 32'h1, 1'b1, 1'b1, "ticlr0_noclr");

        // InitVal=0 periodic: expires every edge
        wr(A_TCFG, 32'h0);
        wr(A_TICLR, 32'h1);
        wr(A_TCFG, 32'h0000_0003);
        rd(1'b1, A_TVAL, 32'h0, 1'b1, 1'b0, "iv0_first");
        rd(1'b1, A_TVAL, 32'h0, 1'b1, 1'b1, "iv0_exp");
        wr(A_TICLR, 32'h1);
        rd(1'b1, A_TVAL, 32'h0, 1'b1, 1'b1, "iv0_refire");
        wr(A_TCFG, 32'h0);
        wr(A_TICLR, 32'h1);
        rd(1'b1, A_TVAL, 32'h0, 1'b1, 1'b0, "iv0_stop");

        // Read-only / write-only / plain registers and unmapped address
        wr(A_TVAL, 32'h0000_1234);
        wr(A_TICLR, 32'hFFFF_FFFF);
        rd(1'b1, A_TVAL,  32'h0, 1'b1, 1'b0, "tval_ro");
        rd(1'b1, A_TICLR, 32'h0, 1'b1, 1'b0, "ticlr_rd0");
        wr(A_TID, 32'hA5A5_0001);
        rd(1'b1, A_TID, 32'hA5A5_0001, 1'b1, 1'b0, "tid_rw");
        wr(14'h043, 32'hFFFF_FFFF);
        rd(1'b1, A_TCFG,  32'h0, 1'b1, 1'b0, "unmapped_wr");
        rd(1'b1, 14'h043, 32'h0, 1'b0, 1'b0, "unmapped_rd");

        // Mid-count disable freezes R, then restart
        wr(A_TCFG, 32'h0000_0009);
        for (int i = 0; i < 3; i++) rd(1'b1, A_TVAL, 32'(8 - i), 1'b1, 1'b0, "mid_cnt");
        wr(A_TCFG, 32'h0000_0008);
        rd(1'b1, A_TVAL, 32'h8, 1'b1, 1'b0, "dis_load");
        idle(10);
        rd(1'b1, A_TVAL, 32'h8, 1'b1, 1'b0, "dis_frozen");
        rd(1'b1, A_TCFG, 32'h8, 1'b1, 1'b0, "dis_tcfg");
        wr(A_TCFG, 32'h0000_0009);
        for (int i = 0; i < 5; i++) rd(1'b1, A_TVAL, 32'(8 - i), 1'b1, 1'b0, "restart_cnt");

        // Reset mid-count while TVAL=3
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        rd(1'b1, A_TVAL, 32'h0,  1'b1, 1'b0, "midrst_tval");
        rd(1'b1, A_TCFG, 32'h0,  1'b1, 1'b0, "midrst_tcfg");
        rd(1'b1, A_TID,  CPU_ID, 1'b1, 1'b0, "midrst_tid");
        rd(1'b1, A_TVAL, 32'h0,  1'b1, 1'b0, "midrst_idle");

        idle(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/csr_timer.md
Name: csr_timer

Overview:
- Constant-timer unit for the LoongArch32 privileged CSR space. Owns TID, TCFG, TVAL and TICLR, counts down, and produces the timer-interrupt pending bit.
- Sits beside the main CSR file, on the same CSR read/write bus.
- Drives the CSR file's is_ti input, which feeds ESTAT[11].
- Also supplies read data for its four CSRs to the CSR read mux.

Parameters:
- TIMER_N, 32, TVAL/TCFG counter width (bits); valid range 8..32; upper bits read as 0.
- CPU_ID, 0, reset value of TID.
- ADDR_W, 14, CSR address width (matches CSRAddrWidth).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- write_en  in  1  CSR write strobe (same cycle as CSR file write).
- write_addr  in  ADDR_W  CSR write address.
- write_data  in  32  CSR write data.
- read_en  in  1  CSR read enable.
- read_addr  in  ADDR_W  CSR read address.
- read_data  out  32  combinational read data; 0 when not hit.
- read_hit  out  1  read_en and read_addr is one of TID/TCFG/TVAL/TICLR.
- is_ti  out  1  timer interrupt pending (registered).

Behaviour:
- Addresses: TID 0x40, TCFG 0x41, TVAL 0x42, TICLR 0x44. All others are ignored for write, and reads return 0 with read_hit=0.
- TCFG fields: [0] En, [1] Periodic, [TIMER_N-1:2] InitVal. Bits above TIMER_N-1 are written as 0 and read 0.
- Reload value: R = {InitVal, 2'b00}.
- Reset: tid=CPU_ID, tcfg=0, tval=0, is_ti=0, state=IDLE, read_data=0, read_hit=0.
- TID: plain read/write register, 32 bits.
- TVAL: read-only. Writes are ignored. Reads return the current count, zero-extended.
- TICLR: reads always 0. A write with write_data[0]=1 clears is_ti at the next edge. A write with bit 0 = 0 has no effect.
- State machine (state is internal):
  - IDLE: no counting; tval holds its value.
  - RUN: counting down.
  - EXPIRED: non-periodic count finished; tval holds 0.
- TCFG write at edge N:
  - tcfg <= write_data and tval <= R at edge N.
  - state <= RUN if write_data[0]=1, else IDLE.
  - This overrides any decrement in the same cycle, and applies from every state, including restart while running.
- RUN, per edge with no TCFG write:
  - tval > 1: tval <= tval-1.
  - tval == 1 or tval == 0: expiry event.
- Expiry event:
  - is_ti <= 1.
  - Periodic=1: tval <= R and state stays RUN.
  - Periodic=0: tval <= 0 and state <= EXPIRED.
- Latency: with InitVal=k (R=4k, k≥1), first expiry is at edge N+4k. is_ti is visible in the cycle after that edge.
- Periodic period: 4k cycles. Count sequence is 4k, 4k-1, …, 1, 4k; the value 0 is never held while periodic.
- InitVal=0 with En=1: tval=0 loaded, and expiry occurs at edge N+1. If periodic, it re-expires every cycle.
- EXPIRED: no further expiry until TCFG is rewritten with En=1.
- Simultaneous TICLR clear and expiry on the same edge: set wins, so is_ti=1.
- TCFG write does not clear is_ti; only TICLR or rst clears it.
- TCFG write with En=0 moves to IDLE; tval = R is loaded and frozen.
- Reset mid-count: all state returns to reset values at the edge; no expiry fires on that edge.
- Read path: purely combinational from current register values. A read in the same cycle as a write returns the pre-write value.
- Read with read_en=0: read_data=0 and read_hit=0.

Test Plan:
- Reset, then read TCFG/TVAL/TICLR/TID → 0/0/0/CPU_ID; is_ti=0; read_hit=1 for each, 0 for address 0x05.
- Write TCFG=0x0000_0009 (En, InitVal=2, one-shot) at edge N → TVAL 8,7,…,1 on successive reads. At edge N+8: TVAL=0, is_ti=1. TVAL stays 0 and no re-fire over 20 further cycles.
- Write TCFG=0x0000_0007 (En, Periodic, InitVal=1) → TVAL sequence 4,3,2,1,4,3…. is_ti rises at edge N+4. Clear it with TICLR=1; it re-sets at edge N+8.
- Periodic InitVal=1 with a TICLR write of 1 on the exact expiry edge → is_ti remains 1. A TICLR write of 0 never clears it.
- Write TVAL=0x1234 and TICLR=0xFFFF_FFFF, then read both → TVAL unchanged, TICLR reads 0. Write TID=0xA5A5_0001 → reads back 0xA5A5_0001.
- Mid-count (TVAL=5) rewrite TCFG with En=0 → TVAL=R frozen, no expiry. Then rewrite with En=1 → restart from R. Assert rst while TVAL=3 → next cycle TVAL=0, TCFG=0, is_ti=0.
